fft_seq_ctrl: RTL and testbench

Frame sequencer for the 16-point FFT path. It admits one frame of input samples into the FFT core and waits out the core's fixed latency. It then drives the bit-reversal reorder stage's `start_sorting` window and drains the 2·N reordered result words (N real, then N imaginary) to a downstream consumer over a valid/ready handshake. It sits between the sample source, the FFT core, the reorder stage and the output consumer, and owns all frame-level timing.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_seq_perf.sv | 43 ++++
 rtl/fft_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 16-point FFT path:
//   - fft_seq_state_t : frame sequencer state encoding (IDLE=0 .. DONE)
//   - FFT_N           : default FFT size
//   - bit_reverse()   : index bit reversal used by the reorder stage
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        SORT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } fft_seq_state_t;

    // Reverse the low nbits of idx; bits above nbits come back as zero.
    function automatic logic [7:0] bit_reverse(input logic [7:0] idx,
                                               input int unsigned nbits);
        logic [7:0] rev;
        rev = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbits)) begin
                rev[int'(nbits) - 1 - i] = idx[i];
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_seq_perf.sv
// -----------------------------------------------------------------------------
// fft_seq_perf
// Optional performance counters for the frame sequencer. Only instantiated
// when FFT_SEQ_PERF_EN is defined.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_frame_done    : one-cycle pulse per completed frame
//   i_stall         : drain cycle with a word presented but not accepted
//   o_frame_cnt     : completed-frame count, wraps modulo 2^16
//   o_stall_cnt     : drain stall-cycle count, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fft_seq_perf
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frame_done,
    input  logic        i_stall,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_stall_cnt
);

    logic [15:0] r_frame_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (i_stall) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_seq_ctrl
// Frame sequencer for the FFT path: admits N_POINTS samples into the FFT core,
// waits FFT_LAT cycles of core latency, runs the reorder-stage capture window
// (start_sorting) for N_POINTS cycles, then drains 2*N_POINTS result words
// (real then imaginary) over a valid/ready handshake.
//
// Optional feature: define FFT_SEQ_PERF_EN to enable frame_cnt / stall_cnt.
// Without it both ports read 0 and no counter flops exist.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   frame_start    : start one frame (only honoured in IDLE)
//   abort          : synchronous return to IDLE from any state
//   in_valid       : source sample available
//   in_ready       : sample accepted while in LOAD
//   fft_in_en      : in_valid & in_ready, FFT core load strobe
//   start_sorting  : reorder capture window, N_POINTS cycles per frame
//   sort_idx       : capture slot during SORT
//   rd_idx         : result word index during DRAIN
//   out_valid      : result word at rd_idx presented
//   out_ready      : consumer accepts the word
//   busy           : sequencer not idle
//   frame_done     : pulse after the last word is accepted
//   ovf_err        : sticky, frame_start seen while busy
//   err_clr        : clears ovf_err (a same-cycle overflow wins)
//   frame_cnt      : completed frames (perf build)
//   stall_cnt      : drain stall cycles (perf build)
// -----------------------------------------------------------------------------
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int N_POINTS = FFT_N,
    parameter int FFT_LAT  = 8,
    parameter int IDX_W    = $clog2(2 * N_POINTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             fft_in_en,
    output logic             start_sorting,
    output logic [IDX_W-1:0] sort_idx,
    output logic [IDX_W-1:0] rd_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             ovf_err,
    input  logic             err_clr,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      stall_cnt
);

    // The shared counter must reach both 2*N-1 (drain) and FFT_LAT-1 (wait).
    localparam int LAT_W = $clog2(FFT_LAT + 1);
    localparam int CNT_W = (IDX_W > LAT_W) ? IDX_W : LAT_W;

    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_N_LAST   = CNT_W'(N_POINTS - 1);
    localparam logic [CNT_W-1:0] C_W_LAST   = CNT_W'(2 * N_POINTS - 1);
    localparam logic [CNT_W-1:0] C_LAT_LAST = (FFT_LAT > 0) ? CNT_W'(FFT_LAT - 1) : '0;

    fft_seq_state_t   r_state;
    fft_seq_state_t   w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_ovf_err;
    logic             w_in_ready;
    logic             w_fft_in_en;

    assign w_in_ready  = (r_state == LOAD);
    assign w_fft_in_en = in_valid & w_in_ready;

    // State and shared counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic. Every transition clears cnt so each state counts
    // from zero; abort overrides whatever the case statement decided.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_state_next = LOAD;
                    w_cnt_next   = '0;
                end
            end
            LOAD: begin
                if (w_fft_in_en) begin
                    if (r_cnt == C_N_LAST) begin
                        // A zero-latency core feeds the reorder stage at once.
                        w_state_next = (FFT_LAT == 0) ? SORT : WAIT;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + C_ONE;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == C_LAT_LAST) begin
                    w_state_next = SORT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + C_ONE;
                end
            end
            SORT: begin
                // The core output cannot be paused, so SORT never stalls.
                if (r_cnt == C_N_LAST) begin
                    w_state_next = DRAIN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + C_ONE;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (r_cnt == C_W_LAST) begin
                        w_state_next = DONE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + C_ONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
        if (abort) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end
    end

    // Overflow flag: a frame_start outside IDLE (including DONE) is dropped
    // and recorded; a same-cycle err_clr loses to the new overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_err <= 1'b0;
        end else if (frame_start && (r_state != IDLE)) begin
            r_ovf_err <= 1'b1;
        end else if (err_clr) begin
            r_ovf_err <= 1'b0;
        end
    end

    assign in_ready      = w_in_ready;
    assign fft_in_en     = w_fft_in_en;
    assign start_sorting = (r_state == SORT);
    assign out_valid     = (r_state == DRAIN);
    assign busy          = (r_state != IDLE);
    assign frame_done    = (r_state == DONE);
    assign sort_idx      = r_cnt[IDX_W-1:0];
    assign rd_idx        = r_cnt[IDX_W-1:0];
    assign ovf_err       = r_ovf_err;

`ifdef FFT_SEQ_PERF_EN
    logic w_perf_done;
    logic w_perf_stall;

    assign w_perf_done  = (r_state == DONE);
    assign w_perf_stall = (r_state == DRAIN) & ~out_ready;

    fft_seq_perf u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_done (w_perf_done),
        .i_stall      (w_perf_stall),
        .o_frame_cnt  (frame_cnt),
        .o_stall_cnt  (stall_cnt)
    );
`else
    assign frame_cnt = 16'd0;
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
module tb_fft_seq_ctrl;

    localparam int N     = 16;
    localparam int LAT   = 8;
    localparam int IDX_W = 5;
`ifdef FFT_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             fft_in_en;
    logic             start_sorting;
    logic [IDX_W-1:0] sort_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             frame_done;
    logic             ovf_err;
    logic             err_clr = 1'b0;
    logic [15:0]      frame_cnt;
    logic [15:0]      stall_cnt;
    logic [48:0]      all_outs;

    always #5 clk = ~clk;

    fft_seq_ctrl #(.N_POINTS(N), .FFT_LAT(LAT), .IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fft_in_en     (fft_in_en),
        .start_sorting (start_sorting),
        .sort_idx      (sort_idx),
        .rd_idx        (rd_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .ovf_err       (ovf_err),
        .err_clr       (err_clr),
        .frame_cnt     (frame_cnt),
        .stall_cnt     (stall_cnt)
    );

    assign all_outs = {in_ready, fft_in_en, start_sorting, sort_idx, rd_idx, out_valid,
                       busy, frame_done, ovf_err, frame_cnt, stall_cnt};

    int n_vec = 0;
    int n_bad = 0;

    // Observations from the last frame driven
    int t_first_ready, t_last_en, t_sort_first, t_ov_first, t_done;
    int n_en, n_sort, n_done, load_cycles, ab_k;
    logic ab_ov, ab_busy, busy_after, ovf_sort, ovf_clr, timed_out;
    int got_q[$];
    int sort_q[$];
    int exp_q[$];
    int frames_done_exp = 0;

    task automatic push_expected(input int nwords);
        for (int i = 0; i < nwords; i++) exp_q.push_back(i);
    endtask

    // Drives one frame and records what the DUT did; callers do the checking.
    task automatic drive_frame(input bit gap, input bit bp, input int abort_at, input bit ovf_test);
        int k = 0;
        int load_k = 0;
        int drain_k = 0;
        t_first_ready = -1; t_last_en = -1; t_sort_first = -1; t_ov_first = -1; t_done = -1;
        n_en = 0; n_sort = 0; n_done = 0; load_cycles = 0; ab_k = -1;
        ab_ov = 1'bx; ab_busy = 1'bx; busy_after = 1'b0; ovf_sort = 1'bx; ovf_clr = 1'bx;
        timed_out = 1'b0;
        got_q.delete(); sort_q.delete();
        forever begin
            frame_start = (k == 0);
            err_clr     = 1'b0;
            abort       = 1'b0;
            in_valid    = in_ready && (!gap || (load_k % 2) == 1);
            out_ready   = out_valid && (!bp || (drain_k % 3) == 2);
            if (abort_at >= 0 && ab_k < 0 && out_valid && int'(rd_idx) == abort_at) begin
                abort = 1'b1;
                ab_k  = k;
            end
            if (ovf_test && start_sorting && t_sort_first < 0) frame_start = 1'b1;
            if (ovf_test && out_valid && t_ov_first < 0) begin
                frame_start = 1'b1;
                err_clr     = 1'b1;
            end
            #1;
            if (in_ready) begin
                load_cycles++;
                load_k++;
                if (t_first_ready < 0) t_first_ready = k;
            end
            if (fft_in_en) begin
                n_en++;
                t_last_en = k;
            end
            if (start_sorting) begin
                n_sort++;
                sort_q.push_back(int'(sort_idx));
                if (t_sort_first < 0) t_sort_first = k;
            end
            if (out_valid) begin
                drain_k++;
                if (t_ov_first < 0) t_ov_first = k;
                if (out_ready && !abort) got_q.push_back(int'(rd_idx));
            end
            if (frame_done) begin
                n_done++;
                if (t_done < 0) t_done = k;
            end
            if (t_done >= 0 && k > t_done && busy) busy_after = 1'b1;
            if (ab_k >= 0 && k == ab_k + 1) begin
                ab_ov   = out_valid;
                ab_busy = busy;
            end
            if (ovf_test && t_sort_first >= 0 && k == t_sort_first + 1) ovf_sort = ovf_err;
            if (ovf_test && t_ov_first >= 0 && k == t_ov_first + 1) ovf_clr = ovf_err;
            @(posedge clk);
            #1;
            k++;
            if (t_done >= 0 && k > t_done + 5) break;
            if (ab_k >= 0 && k > ab_k + 20) break;
            if (k > 700) begin
                timed_out = 1'b1;
                break;
            end
        end
        frame_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if (all_outs !== '0) begin
            n_bad++;
            $display("FAIL reset_hold outputs=%h want 0", all_outs);
        end
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (all_outs !== '0) begin
            n_bad++;
            $display("FAIL reset_release outputs=%h want 0", all_outs);
        end
        $display("reset: outputs=%h after release", all_outs);
    endtask

    task automatic test_abort();
        push_expected(10);
        drive_frame(1'b0, 1'b0, 10, 1'b0);
        n_vec++;
        if (timed_out !== 1'b0 || ab_k < 0) begin
            n_bad++;
            $display("FAIL abort_timeout abort_cycle=%0d timed_out=%0b want abort seen", ab_k, timed_out);
        end
        n_vec++;
        if (ab_ov !== 1'b0 || ab_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle out_valid=%b busy=%b want 0 0", ab_ov, ab_busy);
        end
        n_vec++;
        if (n_done !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done frame_done_pulses=%0d want 0", n_done);
        end
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = (got_q.size() > 0) ? got_q.pop_front() : -1;
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL abort_rd_idx got %0d want %0d", g, e);
            end
        end
        n_vec++;
        if (frame_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL abort_frame_cnt got %0d want 0", frame_cnt);
        end
        $display("abort: aborted at cycle %0d, out_valid=%b busy=%b done=%0d", ab_k, ab_ov, ab_busy, n_done);
    endtask

    task automatic test_nominal(input bit gap, input string tag);
        push_expected(2 * N);
        drive_frame(gap, 1'b0, -1, 1'b0);
        frames_done_exp++;
        n_vec++;
        if (timed_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_timeout got timed_out=1 want frame completion", tag);
        end
        n_vec++;
        if (t_first_ready !== 1) begin
            n_bad++;
            $display("FAIL %s_in_ready_latency got %0d want 1", tag, t_first_ready);
        end
        n_vec++;
        if (n_en !== N || load_cycles !== (gap ? 2 * N : N)) begin
            n_bad++;
            $display("FAIL %s_load en=%0d load_cycles=%0d want %0d %0d", tag, n_en, load_cycles, N, gap ? 2 * N : N);
        end
        n_vec++;
        if (t_sort_first - t_last_en !== LAT + 1 || n_sort !== N) begin
            n_bad++;
            $display("FAIL %s_sort_window delay=%0d len=%0d want %0d %0d", tag, t_sort_first - t_last_en, n_sort, LAT + 1, N);
        end
        for (int i = 0; i < N; i++) begin
            int s = (sort_q.size() > 0) ? sort_q.pop_front() : -1;
            n_vec++;
            if (s !== i) begin
                n_bad++;
                $display("FAIL %s_sort_idx got %0d want %0d", tag, s, i);
            end
        end
        n_vec++;
        if (t_ov_first - t_sort_first !== N) begin
            n_bad++;
            $display("FAIL %s_out_valid_delay got %0d want %0d", tag, t_ov_first - t_sort_first, N);
        end
        n_vec++;
        if (n_done !== 1 || t_done - t_ov_first !== 2 * N || busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done pulses=%0d delay=%0d busy_after=%b want 1 %0d 0", tag, n_done, t_done - t_ov_first, busy_after, 2 * N);
        end
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = (got_q.size() > 0) ? got_q.pop_front() : -1;
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s_rd_idx got %0d want %0d", tag, g, e);
            end
        end
        n_vec++;
        if (got_q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_extra_words got %0d want 0", tag, got_q.size());
        end
        n_vec++;
        if (frame_cnt !== (PERF ? 16'(frames_done_exp) : 16'd0)) begin
            n_bad++;
            $display("FAIL %s_frame_cnt got %0d want %0d", tag, frame_cnt, PERF ? frames_done_exp : 0);
        end
        $display("%s: last_en=%0d sort=%0d first_valid=%0d done=%0d", tag, t_last_en, t_sort_first, t_ov_first, t_done);
    endtask

    task automatic test_backpressure();
        push_expected(2 * N);
        drive_frame(1'b0, 1'b1, -1, 1'b0);
        frames_done_exp++;
        n_vec++;
        if (timed_out !== 1'b0 || n_done !== 1) begin
            n_bad++;
            $display("FAIL bp_done timed_out=%b pulses=%0d want 0 1", timed_out, n_done);
        end
        n_vec++;
        if (t_done - t_ov_first !== 6 * N) begin
            n_bad++;
            $display("FAIL bp_drain_len got %0d want %0d", t_done - t_ov_first, 6 * N);
        end
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = (got_q.size() > 0) ? got_q.pop_front() : -1;
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL bp_rd_idx got %0d want %0d", g, e);
            end
        end
        n_vec++;
        if (got_q.size() !== 0) begin
            n_bad++;
            $display("FAIL bp_extra_words got %0d want 0", got_q.size());
        end
        n_vec++;
        if (stall_cnt !== (PERF ? 16'd64 : 16'd0)) begin
            n_bad++;
            $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, PERF ? 64 : 0);
        end
        $display("backpressure: drain=%0d cycles stall_cnt=%0d", t_done - t_ov_first, stall_cnt);
    endtask

    task automatic test_overflow();
        n_vec++;
        if (ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_initial got %b want 0", ovf_err);
        end
        push_expected(2 * N);
        drive_frame(1'b0, 1'b0, -1, 1'b1);
        frames_done_exp++;
        n_vec++;
        if (ovf_sort !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set got %b want 1", ovf_sort);
        end
        n_vec++;
        if (ovf_clr !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set_wins got %b want 1", ovf_clr);
        end
        n_vec++;
        if (timed_out !== 1'b0 || n_done !== 1 || busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_single_frame done=%0d busy_after=%b want 1 0", n_done, busy_after);
        end
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = (got_q.size() > 0) ? got_q.pop_front() : -1;
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL ovf_rd_idx got %0d want %0d", g, e);
            end
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        n_vec++;
        if (ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear got %b want 0", ovf_err);
        end
        $display("overflow: ovf after sort=%b after clr+ovf=%b after clr=%b", ovf_sort, ovf_clr, ovf_err);
    endtask

    task automatic test_reset_in_wait();
        int n = 0;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        for (int i = 0; i < 100 && n < N; i++) begin
            in_valid    = in_ready;
            frame_start = (n == 3);
            #1;
            if (fft_in_en) n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        frame_start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_vec++;
        if ({busy, in_ready, start_sorting, ovf_err} !== 4'b1001) begin
            n_bad++;
            $display("FAIL rst_wait_state got %b want 1001", {busy, in_ready, start_sorting, ovf_err});
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (all_outs !== '0) begin
            n_bad++;
            $display("FAIL rst_wait_async outputs=%h want 0", all_outs);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (all_outs !== '0) begin
            n_bad++;
            $display("FAIL rst_wait_idle outputs=%h want 0", all_outs);
        end
        push_expected(2 * N);
        drive_frame(1'b0, 1'b0, -1, 1'b0);
        n_vec++;
        if (n_done !== 1 || timed_out !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_recover done=%0d want 1", n_done);
        end
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = (got_q.size() > 0) ? got_q.pop_front() : -1;
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL rst_wait_rd_idx got %0d want %0d", g, e);
            end
        end
        n_vec++;
        if (frame_cnt !== (PERF ? 16'd1 : 16'd0)) begin
            n_bad++;
            $display("FAIL rst_wait_frame_cnt got %0d want %0d", frame_cnt, PERF ? 1 : 0);
        end
        $display("reset_in_wait: outputs cleared, recovery frame done=%0d", n_done);
    endtask

    initial begin
        test_reset();
        test_abort();
        test_nominal(1'b0, "nominal");
        test_nominal(1'b1, "gaps");
        test_backpressure();
        test_overflow();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
